// File: rtl/posit_operand_decoder.sv
// posit_operand_decoder: two-stage posit operand unpacker (sign, scale, hidden-bit fraction).
// S1 captures the operands, their zero/NaR flags, sign and magnitude; S2 decodes regime/exponent/fraction.
// Optional feature macro: POSIT_DE_SPECIAL_CNT_EN adds saturating zero/NaR output counters.
module posit_operand_decoder #(
  parameter int unsigned N  = 32,
  parameter int unsigned ES = 2,
  localparam int unsigned SW = ES + $clog2(N) + 1,
  localparam int unsigned FW = N - ES - 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          sign_a,
  output logic          sign_b,
  output logic [SW-1:0] scale_a,
  output logic [SW-1:0] scale_b,
  output logic [FW-1:0] frac_a,
  output logic [FW-1:0] frac_b,
`ifdef POSIT_DE_SPECIAL_CNT_EN
  output logic [15:0]   zero_cnt,
  output logic [15:0]   nar_cnt,
`endif
  output logic          ZERO_A_DE,
  output logic          NAR_A_DE,
  output logic          ZERO_B_DE,
  output logic          NAR_B_DE
);

  localparam int unsigned CW = 16;

  // Decode a non-special magnitude body (abs[N-2:0]) into {scale, frac}.
  // The top body bit always belongs to the regime run and the second bit is either run or
  // terminator, so only body[N-4:0] can ever reach the exponent/fraction fields.
  function automatic logic [SW+FW-1:0] decode_body(input logic [N-2:0] body);
    logic              r0;
    logic              done;
    int unsigned       run;
    logic [SW-1:0]     k;
    logic [N-4:0]      sh;
    logic [ES-1:0]     e;
    logic [SW-1:0]     scale;
    logic [FW-1:0]     frac;
    r0   = body[N-2];
    run  = 1;
    done = 1'b0;
    for (int i = N - 3; i >= 0; i--) begin
      if (!done && (body[i] == r0)) begin
        run = run + 1;
      end else begin
        done = 1'b1;
      end
    end
    k     = r0 ? SW'(run - 1) : (SW'(0) - SW'(run));
    sh    = body[N-4:0] << (run - 1);
    e     = sh[N-4 -: ES];
    scale = SW'(k << ES) + SW'(e);
    frac  = {1'b1, sh[N-4-ES:0]};
    return {scale, frac};
  endfunction

  // Stage 1 registers
  logic          s1_valid_q, s1_valid_d;
  logic          s1_sign_a_q, s1_sign_a_d, s1_sign_b_q, s1_sign_b_d;
  logic          s1_zero_a_q, s1_zero_a_d, s1_zero_b_q, s1_zero_b_d;
  logic          s1_nar_a_q, s1_nar_a_d, s1_nar_b_q, s1_nar_b_d;
  logic [N-2:0]  s1_body_a_q, s1_body_a_d, s1_body_b_q, s1_body_b_d;

  // Stage 2 (output) registers
  logic          out_valid_q, out_valid_d;
  logic          sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [SW-1:0] scale_a_q, scale_a_d, scale_b_q, scale_b_d;
  logic [FW-1:0] frac_a_q, frac_a_d, frac_b_q, frac_b_d;
  logic          zero_a_q, zero_a_d, zero_b_q, zero_b_d;
  logic          nar_a_q, nar_a_d, nar_b_q, nar_b_d;
`ifdef POSIT_DE_SPECIAL_CNT_EN
  logic [CW-1:0] zero_cnt_q, zero_cnt_d, nar_cnt_q, nar_cnt_d;
`endif

  logic              advance;
  logic              accept;
  logic              emit;
  logic [SW+FW-1:0]  dec_a, dec_b;
  logic [N-1:0]      nar_pattern;

  // Handshake: S2 can take new data when empty or draining; S1 when empty or moving on.
  always_comb begin
    advance     = !out_valid_q || out_ready;
    in_ready    = !s1_valid_q || advance;
    accept      = in_valid && in_ready;
    emit        = out_valid_q && out_ready;
    nar_pattern = {1'b1, {(N-1){1'b0}}};
  end

  // S1: capture flags, sign and two's-complement magnitude body of each operand.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sign_a_d = s1_sign_a_q;
    s1_sign_b_d = s1_sign_b_q;
    s1_zero_a_d = s1_zero_a_q;
    s1_zero_b_d = s1_zero_b_q;
    s1_nar_a_d  = s1_nar_a_q;
    s1_nar_b_d  = s1_nar_b_q;
    s1_body_a_d = s1_body_a_q;
    s1_body_b_d = s1_body_b_q;
    if (accept) begin
      s1_valid_d  = 1'b1;
      s1_sign_a_d = a[N-1];
      s1_sign_b_d = b[N-1];
      s1_zero_a_d = (a == '0);
      s1_zero_b_d = (b == '0);
      s1_nar_a_d  = (a == nar_pattern);
      s1_nar_b_d  = (b == nar_pattern);
      s1_body_a_d = a[N-1] ? (~a[N-2:0] + (N-1)'(1)) : a[N-2:0];
      s1_body_b_d = b[N-1] ? (~b[N-2:0] + (N-1)'(1)) : b[N-2:0];
    end else if (advance) begin
      s1_valid_d  = 1'b0;
    end
  end

  // S2: decode regime/exponent/fraction; special operands carry only their flag.
  always_comb begin
    dec_a       = decode_body(s1_body_a_q);
    dec_b       = decode_body(s1_body_b_q);
    out_valid_d = out_valid_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    scale_a_d   = scale_a_q;
    scale_b_d   = scale_b_q;
    frac_a_d    = frac_a_q;
    frac_b_d    = frac_b_q;
    zero_a_d    = zero_a_q;
    zero_b_d    = zero_b_q;
    nar_a_d     = nar_a_q;
    nar_b_d     = nar_b_q;
    if (advance) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        zero_a_d = s1_zero_a_q;
        zero_b_d = s1_zero_b_q;
        nar_a_d  = s1_nar_a_q;
        nar_b_d  = s1_nar_b_q;
        if (s1_zero_a_q || s1_nar_a_q) begin
          sign_a_d  = 1'b0;
          scale_a_d = '0;
          frac_a_d  = '0;
        end else begin
          sign_a_d  = s1_sign_a_q;
          scale_a_d = dec_a[SW+FW-1:FW];
          frac_a_d  = dec_a[FW-1:0];
        end
        if (s1_zero_b_q || s1_nar_b_q) begin
          sign_b_d  = 1'b0;
          scale_b_d = '0;
          frac_b_d  = '0;
        end else begin
          sign_b_d  = s1_sign_b_q;
          scale_b_d = dec_b[SW+FW-1:FW];
          frac_b_d  = dec_b[FW-1:0];
        end
      end
    end
  end

`ifdef POSIT_DE_SPECIAL_CNT_EN
  // Saturating counts of emitted pairs carrying a zero and/or NaR operand.
  always_comb begin
    zero_cnt_d = zero_cnt_q;
    nar_cnt_d  = nar_cnt_q;
    if (emit && (zero_a_q || zero_b_q) && (zero_cnt_q != {CW{1'b1}})) begin
      zero_cnt_d = zero_cnt_q + CW'(1);
    end
    if (emit && (nar_a_q || nar_b_q) && (nar_cnt_q != {CW{1'b1}})) begin
      nar_cnt_d = nar_cnt_q + CW'(1);
    end
  end

  // Counter state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_cnt_q <= '0;
      nar_cnt_q  <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
      nar_cnt_q  <= nar_cnt_d;
    end
  end

  assign zero_cnt = zero_cnt_q;
  assign nar_cnt  = nar_cnt_q;
`else
  // Keeps emit referenced when the counters are compiled out.
  logic emit_unused;
  assign emit_unused = emit;
`endif

  // Pipeline state registers; reset drops every in-flight pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_a_q <= 1'b0;
      s1_sign_b_q <= 1'b0;
      s1_zero_a_q <= 1'b0;
      s1_zero_b_q <= 1'b0;
      s1_nar_a_q  <= 1'b0;
      s1_nar_b_q  <= 1'b0;
      s1_body_a_q <= '0;
      s1_body_b_q <= '0;
      out_valid_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      scale_a_q   <= '0;
      scale_b_q   <= '0;
      frac_a_q    <= '0;
      frac_b_q    <= '0;
      zero_a_q    <= 1'b0;
      zero_b_q    <= 1'b0;
      nar_a_q     <= 1'b0;
      nar_b_q     <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_a_q <= s1_sign_a_d;
      s1_sign_b_q <= s1_sign_b_d;
      s1_zero_a_q <= s1_zero_a_d;
      s1_zero_b_q <= s1_zero_b_d;
      s1_nar_a_q  <= s1_nar_a_d;
      s1_nar_b_q  <= s1_nar_b_d;
      s1_body_a_q <= s1_body_a_d;
      s1_body_b_q <= s1_body_b_d;
      out_valid_q <= out_valid_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      scale_a_q   <= scale_a_d;
      scale_b_q   <= scale_b_d;
      frac_a_q    <= frac_a_d;
      frac_b_q    <= frac_b_d;
      zero_a_q    <= zero_a_d;
      zero_b_q    <= zero_b_d;
      nar_a_q     <= nar_a_d;
      nar_b_q     <= nar_b_d;
    end
  end

  assign out_valid = out_valid_q;
  assign sign_a    = sign_a_q;
  assign sign_b    = sign_b_q;
  assign scale_a   = scale_a_q;
  assign scale_b   = scale_b_q;
  assign frac_a    = frac_a_q;
  assign frac_b    = frac_b_q;
  assign ZERO_A_DE = zero_a_q;
  assign ZERO_B_DE = zero_b_q;
  assign NAR_A_DE  = nar_a_q;
  assign NAR_B_DE  = nar_b_q;

endmodule

// File: tb/tb_posit_operand_decoder.sv
// Testbench for posit_operand_decoder: directed vector table, random traffic against a
// reference decoder, backpressure and mid-flight reset sequences.
module tb_posit_operand_decoder;

  localparam int unsigned N  = 32;
  localparam int unsigned ES = 2;
  localparam int unsigned SW = 8;
  localparam int unsigned FW = 28;

  typedef struct packed {
    logic          s;
    logic [SW-1:0] sc;
    logic [FW-1:0] f;
    logic          z;
    logic          n;
  } half_t;

  typedef struct packed {
    half_t a;
    half_t b;
  } exp_t;

  typedef struct packed {
    logic [N-1:0] a;
    logic [N-1:0] b;
    exp_t         e;
  } vec_t;

  logic          clk, rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [N-1:0]  a, b;
  logic          sign_a, sign_b;
  logic [SW-1:0] scale_a, scale_b;
  logic [FW-1:0] frac_a, frac_b;
  logic          ZERO_A_DE, NAR_A_DE, ZERO_B_DE, NAR_B_DE;
`ifdef POSIT_DE_SPECIAL_CNT_EN
  logic [15:0]   zero_cnt, nar_cnt;
  int            exp_zc = 0;
  int            exp_nc = 0;
`endif

  posit_operand_decoder #(.N(N), .ES(ES)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_a(sign_a), .sign_b(sign_b),
    .scale_a(scale_a), .scale_b(scale_b),
    .frac_a(frac_a), .frac_b(frac_b),
`ifdef POSIT_DE_SPECIAL_CNT_EN
    .zero_cnt(zero_cnt), .nar_cnt(nar_cnt),
`endif
    .ZERO_A_DE(ZERO_A_DE), .NAR_A_DE(NAR_A_DE),
    .ZERO_B_DE(ZERO_B_DE), .NAR_B_DE(NAR_B_DE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sbq[$];
  bit   sb_en    = 1'b0;
  int   emitted  = 0;

  function automatic half_t h(input logic s, input logic [SW-1:0] sc, input logic [FW-1:0] f,
                              input logic z, input logic n);
    half_t r;
    r.s = s; r.sc = sc; r.f = f; r.z = z; r.n = n;
    return r;
  endfunction

  // Reference decode written from the posit definition using integer arithmetic.
  function automatic half_t ref_dec(input logic [N-1:0] x);
    half_t  r;
    longint ax, rem, fb;
    int     r0, m, k, rl, e, fl, i;
    r = '0;
    r.z = (x == 32'h0000_0000);
    r.n = (x == 32'h8000_0000);
    if (r.z || r.n) return r;
    r.s = x[N-1];
    ax  = r.s ? (64'sd4294967296 - longint'(x)) : longint'(x);
    r0  = int'((ax >> 30) & 1);
    m   = 0;
    i   = 30;
    while (i >= 0 && int'((ax >> i) & 1) == r0) begin
      m++;
      i--;
    end
    k   = (r0 == 1) ? (m - 1) : -m;
    rl  = (m == 31) ? 0 : (31 - m - 1);
    rem = ax & ((64'sd1 << rl) - 1);
    if (rl >= ES) begin
      e  = int'(rem >> (rl - ES));
      fl = rl - ES;
      fb = rem & ((64'sd1 << fl) - 1);
    end else begin
      e  = int'(rem << (ES - rl));
      fl = 0;
      fb = 0;
    end
    r.sc = SW'(k * 4 + e);
    r.f  = FW'((64'sd1 << 27) | (fb << (27 - fl)));
    return r;
  endfunction

  function automatic exp_t model(input logic [N-1:0] xa, input logic [N-1:0] xb);
    exp_t r;
    r.a = ref_dec(xa);
    r.b = ref_dec(xb);
    return r;
  endfunction

  function automatic exp_t act_now();
    exp_t r;
    r.a = h(sign_a, scale_a, frac_a, ZERO_A_DE, NAR_A_DE);
    r.b = h(sign_b, scale_b, frac_b, ZERO_B_DE, NAR_B_DE);
    return r;
  endfunction

  task automatic chk_pair(input string name, input exp_t want);
    exp_t got;
    got = act_now();
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got a{s=%0d sc=%0d f=%h z=%0d n=%0d} b{s=%0d sc=%0d f=%h z=%0d n=%0d} want a{s=%0d sc=%0d f=%h z=%0d n=%0d} b{s=%0d sc=%0d f=%h z=%0d n=%0d}",
               name, got.a.s, $signed(got.a.sc), got.a.f, got.a.z, got.a.n,
               got.b.s, $signed(got.b.sc), got.b.f, got.b.z, got.b.n,
               want.a.s, $signed(want.a.sc), want.a.f, want.a.z, want.a.n,
               want.b.s, $signed(want.b.sc), want.b.f, want.b.z, want.b.n);
    end
  endtask

  task automatic chk_val(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Scoreboard: predict on input handshake, compare in order on output handshake.
  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (out_valid && out_ready) begin
        emitted++;
        if (sbq.size() == 0) begin
          n_checks++;
          $display("FAIL stream: unexpected output, got scale_a=%0d want none", $signed(scale_a));
        end else begin
          chk_pair("stream", sbq.pop_front());
        end
      end
      if (in_valid && in_ready) sbq.push_back(model(a, b));
    end
  end

`ifdef POSIT_DE_SPECIAL_CNT_EN
  // Expected counter values, advanced on each output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if ((ZERO_A_DE || ZERO_B_DE) && exp_zc < 65535) exp_zc++;
      if ((NAR_A_DE || NAR_B_DE) && exp_nc < 65535) exp_nc++;
    end
  end
  always @(posedge rst) begin
    exp_zc = 0;
    exp_nc = 0;
  end
`endif

  function automatic logic [N-1:0] rnd_posit();
    logic [N-1:0] v;
    int           sel;
    v   = N'($urandom);
    sel = int'($urandom_range(0, 9));
    case (sel)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return v >> $urandom_range(0, 31);
      3:       return ~(v >> $urandom_range(0, 31));
      4:       return {1'b0, ~(v[N-2:0] >> $urandom_range(0, 30))};
      default: return v;
    endcase
  endfunction

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && (out_valid || sbq.size() != 0); i++) @(negedge clk);
    chk_val(name, longint'(sbq.size() == 0 && !out_valid), 1);
  endtask

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    int   e0;
    exp_t zero_exp;
    zero_exp  = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{a: 32'h4000_0000, b: 32'hC000_0000,
                e: '{a: h(0, 8'd0, 28'h800_0000, 0, 0), b: h(1, 8'd0, 28'h800_0000, 0, 0)}};
    vecs[1] = '{a: 32'h4800_0000, b: 32'h7FFF_FFFF,
                e: '{a: h(0, 8'd1, 28'h800_0000, 0, 0), b: h(0, 8'd120, 28'h800_0000, 0, 0)}};
    vecs[2] = '{a: 32'h0000_0001, b: 32'h8000_0000,
                e: '{a: h(0, 8'h88, 28'h800_0000, 0, 0), b: h(0, 8'd0, 28'h0, 0, 1)}};
    vecs[3] = '{a: 32'h0000_0000, b: 32'h4000_0000,
                e: '{a: h(0, 8'd0, 28'h0, 1, 0), b: h(0, 8'd0, 28'h800_0000, 0, 0)}};
    vecs[4] = '{a: 32'h5A5A_5A5A, b: 32'hFFFF_FFFF,
                e: '{a: h(0, 8'd3, 28'hA5A_5A5A, 0, 0), b: h(1, 8'h88, 28'h800_0000, 0, 0)}};
    vecs[5] = '{a: 32'h8000_0001, b: 32'h3FFF_FFFF,
                e: '{a: h(1, 8'd120, 28'h800_0000, 0, 0), b: h(0, 8'hFF, 28'hFFF_FFFF, 0, 0)}};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_val("reset_out_valid", longint'(out_valid), 0);
    chk_val("reset_in_ready", longint'(in_ready), 1);
    chk_pair("reset_outputs", zero_exp);
`ifdef POSIT_DE_SPECIAL_CNT_EN
    chk_val("reset_zero_cnt", longint'(zero_cnt), 0);
    chk_val("reset_nar_cnt", longint'(nar_cnt), 0);
`endif
    rst = 1'b0;

    // Directed table, one pair at a time, checking the two-register latency
    out_ready = 1'b1;
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      a = vecs[v].a; b = vecs[v].b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk_val($sformatf("lat_s1_v%0d", v), longint'(out_valid), 0);
      @(negedge clk);
      chk_val($sformatf("lat_s2_v%0d", v), longint'(out_valid), 1);
      chk_pair($sformatf("vec%0d", v), vecs[v].e);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    sb_en = 1'b1;

    // Random traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = rnd_posit();
      b         = rnd_posit();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    drain("random_drain");

    // Backpressure: S2 holds, S1 fills, third pair is refused until drain
    e0 = emitted;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a = vecs[1].a; b = vecs[1].b;
    @(posedge clk); #1;
    a = vecs[4].a; b = vecs[4].b;
    @(posedge clk); #1;
    a = vecs[5].a; b = vecs[5].b;
    @(negedge clk);
    chk_val("bp_in_ready_low", longint'(in_ready), 0);
    chk_val("bp_out_valid", longint'(out_valid), 1);
    chk_pair("bp_hold0", vecs[1].e);
    for (int c = 1; c < 4; c++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk_val("bp_in_ready_held", longint'(in_ready), 0);
      chk_pair($sformatf("bp_hold%0d", c), vecs[1].e);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk_val("bp_in_ready_release", longint'(in_ready), 1);
    @(posedge clk); #1;
    drain("bp_drain");
    chk_val("bp_emitted", longint'(emitted - e0), 3);

    // Reset with two pairs in flight
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; a = vecs[0].a; b = vecs[0].b;
    @(posedge clk); #1;
    a = vecs[2].a; b = vecs[2].b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk_val("flush_pre_in_ready", longint'(in_ready), 0);
    sb_en = 1'b0;
    rst   = 1'b1;
    #1;
    chk_val("flush_out_valid", longint'(out_valid), 0);
    chk_val("flush_in_ready", longint'(in_ready), 1);
    chk_pair("flush_outputs", zero_exp);
    sbq.delete();
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk_val($sformatf("flush_no_stale%0d", c), longint'(out_valid), 0);
    end

    // Counters after a zero/NaR pair
    sb_en = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; a = vecs[2].a; b = vecs[3].a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("final_drain");
`ifdef POSIT_DE_SPECIAL_CNT_EN
    @(negedge clk);
    chk_val("zero_cnt", longint'(zero_cnt), longint'(exp_zc));
    chk_val("nar_cnt", longint'(nar_cnt), longint'(exp_nc));
    chk_val("zero_cnt_post_reset", longint'(zero_cnt), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
